iob_eth_dma_burst: RTL

// Parametrised AXI4 burst DMA engine between the Ethernet packet buffer and external memory.

---
 rtl/iob_eth_dma_burst.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/iob_eth_dma_burst.sv
// iob_eth_dma_burst: AXI4 INCR burst DMA between the Ethernet buffer RAM and memory.
// One burst outstanding at a time. Bursts never cross a 4 KB boundary.
module iob_eth_dma_burst #(
    parameter int unsigned AXI_ADDR_W    = 32,
    parameter int unsigned AXI_DATA_W    = 32,
    parameter int unsigned AXI_ID_W      = 1,
    parameter int unsigned BUF_ADDR_W    = 9,
    parameter int unsigned MAX_BURST_LEN = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      dma_run_i,
    input  logic                      dma_dir_i,
    input  logic [AXI_ADDR_W-1:0]     dma_addr_i,
    input  logic [BUF_ADDR_W-1:0]     dma_start_index_i,
    input  logic [BUF_ADDR_W:0]       dma_len_i,
    output logic                      dma_ready_o,
    output logic                      dma_error_o,
    output logic [BUF_ADDR_W-1:0]     buf_addr_o,
    output logic                      buf_re_o,
    input  logic [AXI_DATA_W-1:0]     buf_rdata_i,
    output logic                      buf_we_o,
    output logic [AXI_DATA_W/8-1:0]   buf_wstrb_o,
    output logic [AXI_DATA_W-1:0]     buf_wdata_o,
    output logic [AXI_ID_W-1:0]       m_axi_awid_o,
    output logic [AXI_ADDR_W-1:0]     m_axi_awaddr_o,
    output logic [7:0]                m_axi_awlen_o,
    output logic [2:0]                m_axi_awsize_o,
    output logic [1:0]                m_axi_awburst_o,
    output logic                      m_axi_awlock_o,
    output logic [3:0]                m_axi_awcache_o,
    output logic [2:0]                m_axi_awprot_o,
    output logic [3:0]                m_axi_awqos_o,
    output logic                      m_axi_awvalid_o,
    input  logic                      m_axi_awready_i,
    output logic [AXI_DATA_W-1:0]     m_axi_wdata_o,
    output logic [AXI_DATA_W/8-1:0]   m_axi_wstrb_o,
    output logic                      m_axi_wlast_o,
    output logic                      m_axi_wvalid_o,
    input  logic                      m_axi_wready_i,
    input  logic [1:0]                m_axi_bresp_i,
    input  logic                      m_axi_bvalid_i,
    output logic                      m_axi_bready_o,
    output logic [AXI_ID_W-1:0]       m_axi_arid_o,
    output logic [AXI_ADDR_W-1:0]     m_axi_araddr_o,
    output logic [7:0]                m_axi_arlen_o,
    output logic [2:0]                m_axi_arsize_o,
    output logic [1:0]                m_axi_arburst_o,
    output logic                      m_axi_arlock_o,
    output logic [3:0]                m_axi_arcache_o,
    output logic [2:0]                m_axi_arprot_o,
    output logic [3:0]                m_axi_arqos_o,
    output logic                      m_axi_arvalid_o,
    input  logic                      m_axi_arready_i,
    input  logic [AXI_DATA_W-1:0]     m_axi_rdata_i,
    input  logic [1:0]                m_axi_rresp_i,
    input  logic                      m_axi_rlast_i,
    input  logic                      m_axi_rvalid_i,
    output logic                      m_axi_rready_o
);

    localparam int unsigned BYTES = AXI_DATA_W / 8;
    localparam int unsigned OFFS  = $clog2(BYTES);
    localparam int unsigned LEN_W = BUF_ADDR_W + 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAddr = 2'd1;
    localparam logic [1:0] StData = 2'd2;
    localparam logic [1:0] StResp = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  dir_q, dir_d;
    logic                  err_q, err_d;
    logic [AXI_ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]      rem_q, rem_d;
    logic [BUF_ADDR_W-1:0] ptr_q, ptr_d;
    logic [8:0]            fetch_q, fetch_d;
    logic [8:0]            send_q, send_d;
    logic [1:0]            cnt_q;
    logic                  re_q, wr_ptr_q, rd_ptr_q;
    logic [AXI_DATA_W-1:0] fifo0_q, fifo1_q;

    logic [31:0] to4k, beats;
    logic [7:0]  ax_len;
    logic        in_addr, in_data, ax_hs, wvalid, pop, w_last, r_hs, buf_re;

    // Burst sizing: remaining words, MAX_BURST_LEN and distance to the next 4 KB boundary
    always_comb begin
        to4k  = (32'h1000 - 32'(addr_q[11:0])) >> OFFS;
        beats = 32'(MAX_BURST_LEN);
        if (32'(rem_q) < beats) beats = 32'(rem_q);
        if (to4k < beats) beats = to4k;
        ax_len = 8'(beats - 32'd1);
    end

    assign in_addr = (state_q == StAddr);
    assign in_data = (state_q == StData);
    assign ax_hs   = in_addr && (dir_q ? m_axi_awready_i : m_axi_arready_i);
    assign wvalid  = in_data && dir_q && (cnt_q != 2'd0);
    assign pop     = wvalid && m_axi_wready_i;
    assign w_last  = (send_q == 9'd1);
    assign r_hs    = in_data && !dir_q && m_axi_rvalid_i;
    // Prefetch only while the skid FIFO (plus the read in flight) has a free slot
    assign buf_re  = in_data && dir_q && (fetch_q != 9'd0) &&
                     ((({1'b0, cnt_q} + {2'b00, re_q}) - {2'b00, pop}) < 3'd2);

    // Transfer control: FSM, address/length bookkeeping and sticky error
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        err_d   = err_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        ptr_d   = ptr_q;
        fetch_d = fetch_q;
        send_d  = send_q;
        if (buf_re) fetch_d = fetch_q - 9'd1;
        if (pop) send_d = send_q - 9'd1;
        if (buf_re || r_hs) ptr_d = ptr_q + 1'b1;
        case (state_q)
            StIdle: begin
                if (dma_run_i) begin
                    err_d = 1'b0;
                    if (dma_len_i != '0) begin
                        addr_d  = dma_addr_i;
                        rem_d   = dma_len_i;
                        ptr_d   = dma_start_index_i;
                        dir_d   = dma_dir_i;
                        state_d = StAddr;
                    end
                end
            end
            StAddr: begin
                if (ax_hs) begin
                    addr_d  = addr_q + AXI_ADDR_W'(beats << OFFS);
                    rem_d   = rem_q - LEN_W'(beats);
                    fetch_d = 9'(beats);
                    send_d  = 9'(beats);
                    state_d = StData;
                end
            end
            StData: begin
                if (dir_q) begin
                    if (pop && w_last) state_d = StResp;
                end else if (r_hs) begin
                    if (m_axi_rresp_i != 2'b00) err_d = 1'b1;
                    // rlast ends the burst even if the beat count disagrees
                    if (m_axi_rlast_i) state_d = (rem_q == '0) ? StIdle : StAddr;
                end
            end
            default: begin
                if (m_axi_bvalid_i) begin
                    if (m_axi_bresp_i != 2'b00) err_d = 1'b1;
                    state_d = (rem_q == '0) ? StIdle : StAddr;
                end
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            rem_q   <= '0;
            ptr_q   <= '0;
            fetch_q <= '0;
            send_q  <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            ptr_q   <= ptr_d;
            fetch_q <= fetch_d;
            send_q  <= send_d;
        end
    end

    // Write-data skid FIFO: buffer data lands one cycle after buf_re
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 2'd0;
            re_q     <= 1'b0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            fifo0_q  <= '0;
            fifo1_q  <= '0;
        end else begin
            re_q  <= buf_re;
            cnt_q <= (cnt_q + 2'(re_q)) - 2'(pop);
            if (re_q) begin
                if (wr_ptr_q) fifo1_q <= buf_rdata_i;
                else          fifo0_q <= buf_rdata_i;
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
        end
    end

    assign dma_ready_o = (state_q == StIdle);
    assign dma_error_o = err_q;

    assign buf_addr_o  = ptr_q;
    assign buf_re_o    = buf_re;
    assign buf_we_o    = r_hs;
    assign buf_wstrb_o = r_hs ? '1 : '0;
    assign buf_wdata_o = r_hs ? m_axi_rdata_i : '0;

    assign m_axi_awid_o    = '0;
    assign m_axi_awaddr_o  = (in_addr && dir_q) ? addr_q : '0;
    assign m_axi_awlen_o   = (in_addr && dir_q) ? ax_len : 8'd0;
    assign m_axi_awsize_o  = 3'(OFFS);
    assign m_axi_awburst_o = 2'b01;
    assign m_axi_awlock_o  = 1'b0;
    assign m_axi_awcache_o = 4'b0011;
    assign m_axi_awprot_o  = 3'b000;
    assign m_axi_awqos_o   = 4'b0000;
    assign m_axi_awvalid_o = in_addr && dir_q;

    assign m_axi_wdata_o  = rd_ptr_q ? fifo1_q : fifo0_q;
    assign m_axi_wstrb_o  = '1;
    assign m_axi_wlast_o  = wvalid && w_last;
    assign m_axi_wvalid_o = wvalid;
    assign m_axi_bready_o = (state_q == StResp);

    assign m_axi_arid_o    = '0;
    assign m_axi_araddr_o  = (in_addr && !dir_q) ? addr_q : '0;
    assign m_axi_arlen_o   = (in_addr && !dir_q) ? ax_len : 8'd0;
    assign m_axi_arsize_o  = 3'(OFFS);
    assign m_axi_arburst_o = 2'b01;
    assign m_axi_arlock_o  = 1'b0;
    assign m_axi_arcache_o = 4'b0011;
    assign m_axi_arprot_o  = 3'b000;
    assign m_axi_arqos_o   = 4'b0000;
    assign m_axi_arvalid_o = in_addr && !dir_q;
    assign m_axi_rready_o  = in_data && !dir_q;

endmodule
